// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles the two requester handshakes, the shared result bus and the ALU
//   issue/return signals seen by alu_arbiter.
//
//   slave  : the arbiter's view (requests and ALU returns in, everything else out)
//   master : the environment's view (requesters plus the ALU datapath)
//
//   Requester X : ReqX, FuncX[3:0], AX, BX -> AckX, DoneX
//   Shared      : Result, ResFlags[3:0] (Z,C,N,V from bit0), Err, Busy
//   ALU side    : AluA, AluB, AluFunc[3:0], AluOE_N -> AluRes, AluFlags[3:0]
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int BitWidth = 8
);
    logic                Req0;
    logic [3:0]          Func0;
    logic [BitWidth-1:0] A0;
    logic [BitWidth-1:0] B0;
    logic                Ack0;
    logic                Done0;

    logic                Req1;
    logic [3:0]          Func1;
    logic [BitWidth-1:0] A1;
    logic [BitWidth-1:0] B1;
    logic                Ack1;
    logic                Done1;

    logic [BitWidth-1:0] Result;
    logic [3:0]          ResFlags;
    logic                Err;
    logic                Busy;

    logic [BitWidth-1:0] AluA;
    logic [BitWidth-1:0] AluB;
    logic [3:0]          AluFunc;
    logic                AluOE_N;
    logic [BitWidth-1:0] AluRes;
    logic [3:0]          AluFlags;

    modport slave (
        input  Req0, Func0, A0, B0, Req1, Func1, A1, B1, AluRes, AluFlags,
        output Ack0, Done0, Ack1, Done1, Result, ResFlags, Err, Busy,
               AluA, AluB, AluFunc, AluOE_N
    );

    modport master (
        output Req0, Func0, A0, B0, Req1, Func1, A1, B1, AluRes, AluFlags,
        input  Ack0, Done0, Ack1, Done1, Result, ResFlags, Err, Busy,
               AluA, AluB, AluFunc, AluOE_N
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter/sequencer sharing one ALU between two requesters.
//   A grant latches the winner's operands onto the ALU inputs, waits
//   AluLatency edges, captures result and flags, and pulses the winner's Done.
//   Illegal function codes (Func[3] = 1) never reach the ALU; they complete
//   one edge after the grant with Err, Result = 0 and ResFlags = 0.
//
//   Clk     : rising-edge clock
//   Reset_N : asynchronous active-low reset
//   bus     : alu_arbiter_if.slave (requesters, shared result, ALU issue/return)
//
//   AluLatency must lie in 1..15 (it is loaded into a 4-bit counter).
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int BitWidth   = 8,
    parameter int AluLatency = 2
) (
    input  logic         Clk,
    input  logic         Reset_N,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;       // requester of the op in flight
    logic                illegal_q, illegal_d;   // op in flight had an illegal Func
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                err_q, err_d, busy_q, busy_d, oe_n_q, oe_n_d;
    logic [BitWidth-1:0] result_q, result_d;
    logic [BitWidth-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]          flags_q, flags_d, alu_func_q, alu_func_d;

    logic                winner;
    logic [3:0]          win_func;
    logic [BitWidth-1:0] win_a, win_b;

    // A lone request wins outright; under contention the side that did not
    // win the last contention goes first.
    always_comb begin
        if (bus.Req0 && bus.Req1) winner = ~last_grant_q;
        else                      winner = bus.Req1;
    end

    assign win_func = winner ? bus.Func1 : bus.Func0;
    assign win_a    = winner ? bus.A1    : bus.A0;
    assign win_b    = winner ? bus.B1    : bus.B0;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        illegal_d    = illegal_q;
        result_d     = result_q;
        flags_d      = flags_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_func_d   = alu_func_q;
        oe_n_d       = oe_n_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    owner_d = winner;
                    if (bus.Req0 && bus.Req1) last_grant_d = winner;
                    alu_a_d    = win_a;
                    alu_b_d    = win_b;
                    alu_func_d = win_func;
                    ack0_d     = ~winner;
                    ack1_d     = winner;
                    cnt_d      = 4'(AluLatency);
                    if (!win_func[3]) begin
                        oe_n_d    = 1'b0;
                        illegal_d = 1'b0;
                        state_d   = EXEC;
                    end else begin
                        // No ALU issue: the result is forced to zero now and
                        // Done/Err follow on the next edge from DONE.
                        result_d  = '0;
                        flags_d   = '0;
                        illegal_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end

            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = bus.AluRes;
                    flags_d  = bus.AluFlags;
                    oe_n_d   = 1'b1;
                    done0_d  = ~owner_q;
                    done1_d  = owner_q;
                    state_d  = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
                if (illegal_q) begin
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    err_d     = 1'b1;
                    illegal_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            illegal_q    <= 1'b0;
            result_q     <= '0;
            flags_q      <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_func_q   <= 4'd0;
            oe_n_q       <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            illegal_q    <= illegal_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_func_q   <= alu_func_d;
            oe_n_q       <= oe_n_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.Ack0     = ack0_q;
    assign bus.Ack1     = ack1_q;
    assign bus.Done0    = done0_q;
    assign bus.Done1    = done1_q;
    assign bus.Result   = result_q;
    assign bus.ResFlags = flags_q;
    assign bus.Err      = err_q;
    assign bus.Busy     = busy_q;
    assign bus.AluA     = alu_a_q;
    assign bus.AluB     = alu_b_q;
    assign bus.AluFunc  = alu_func_q;
    assign bus.AluOE_N  = oe_n_q;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-port round-robin arbiter and sequencer sharing one ALU between two requesters.
- Handshakes each requester, latches its operands and function code, and drives the ALU A/B/Func inputs plus its active-low output enable.
- Waits a fixed ALU latency, then captures result and flags and returns them to the winning requester with a one-cycle done pulse.
- Sits between the control unit / DMA-side requesters and the shared ALU datapath.

Parameters:
- BitWidth, 8, operand and result width; must match the ALU.
- AluLatency, 2, clock edges from operand issue to result capture; legal range is 1 to 15.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset_N  input  1  asynchronous, active-low reset.
- Req0  input  1  requester 0 operation request.
- Func0  input  4  requester 0 ALU function code.
- A0  input  BitWidth  requester 0 operand A.
- B0  input  BitWidth  requester 0 operand B.
- Ack0  output  1  one-cycle pulse: requester 0 operands latched.
- Done0  output  1  one-cycle pulse: requester 0 result valid.
- Req1, Func1, A1, B1, Ack1, Done1: same as requester 0, for requester 1.
- Result  output  BitWidth  captured ALU result; shared by both requesters.
- ResFlags  output  4  captured flags: bit0 Z, bit1 C, bit2 N, bit3 V.
- Err  output  1  high together with DoneX when Func is illegal.
- Busy  output  1  high whenever the state is not IDLE.
- AluA  output  BitWidth  drives ALU A.
- AluB  output  BitWidth  drives ALU B.
- AluFunc  output  4  drives ALU Func.
- AluOE_N  output  1  ALU output enable, active low.
- AluRes  input  BitWidth  ALU low result.
- AluFlags  input  4  ALU flags.

Behaviour:
- Reset (asynchronous on Reset_N low) sets:
  - all outputs to 0, except AluOE_N = 1;
  - state = IDLE, Cnt = 0;
  - LastGrant = 1, so requester 0 wins the first contention.
- Reset asserted mid-operation aborts the operation: no DoneX and no Result update. Outputs take reset values immediately.
- States are IDLE, EXEC and DONE. All outputs are registered.
- IDLE, sampled on a rising edge:
  - No Req high: stay in IDLE.
  - Exactly one Req high: grant that requester.
  - Both Req high: grant the requester not equal to LastGrant, then update LastGrant.
  - On a grant at edge k: AluA/AluB/AluFunc are loaded from the winner; AckX = 1 for cycle k only; Cnt = AluLatency.
  - Legal Func (Func[3] = 0, codes 0 to 7): AluOE_N = 0 and next state is EXEC.
  - Illegal Func (Func[3] = 1): AluOE_N stays 1, there is no ALU issue, and next state is DONE.
  - For the illegal case at edge k: Result = 0, ResFlags = 0, Err = 1, and DoneX rises at edge k+1.
- EXEC:
  - Each edge decrements Cnt and clears AckX.
  - On the edge where Cnt == 1: Result = AluRes, ResFlags = AluFlags, AluOE_N = 1, DoneX = 1, Err = 0, next state DONE.
- DONE: clears DoneX and Err; next state IDLE. Result and ResFlags hold until the next capture.
- Timing:
  - Done rises exactly AluLatency edges after Ack rises.
  - The next grant is earliest at edge k+AluLatency+2.
- Requester obligations:
  - Hold ReqX, FuncX, AX and BX stable until AckX.
  - Drop ReqX after AckX; if ReqX is still high in IDLE, it is treated as a new request.
- Any ReqX deasserted before the sampling edge is not granted and leaves no side effect.
- A requester whose Req arrives while Busy waits; it is not queued beyond its held Req level.
- A losing requester under contention is guaranteed the next grant if it keeps Req high (starvation-free).
- AluA, AluB and AluFunc hold their last values outside EXEC. Only AluOE_N gates the ALU output.

Test Plan:
- Reset, then Req0 with Func = 0 (add), A0 = 8'h7F, B0 = 8'h01 -> Ack0 at grant edge; AluOE_N low for 2 cycles; Done0 two edges later; Result = 8'h80; ResFlags = 4'b1100; Done1 never asserts.
- Req0 and Req1 high at the same edge after reset, both held -> requester 0 granted first, then requester 1; repeat with both held -> grant order alternates 0,1,0,1; each Done pulse is exactly one cycle.
- Req1 with Func = 4'b1000 -> Ack1, then Done1 with Err = 1, Result = 0, ResFlags = 0; AluOE_N remains 1 throughout.
- Req0 with Func = 1 (sub), A0 = 8'h05, B0 = 8'h05 -> Result = 8'h00 with ResFlags bit0 = 1. Then Req1 arriving while Busy is held off until the DONE->IDLE transition.
- Reset_N pulsed low during EXEC -> no Done, AluOE_N = 1 immediately, Busy = 0; a subsequent Req1-only request is granted normally.
- With AluLatency = 1 and AluLatency = 4 -> Done rises exactly 1 and 4 edges after Ack respectively.
